// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache.
// Hits are served in one cycle; misses request the word from the memory controller and bypass it on return.
module if_fetch_icache #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        ic_inv_i,
  output logic        inst_fe_o,
  output logic [31:0] inst_fpc_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i,
  input  logic        inst_ok_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {RUN, MISS} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc, pc_d;
  logic [31:0]        if_pc_d, if_inst_d;
  logic               if_valid_d;

  logic [LINES-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];

  logic [INDEX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]   pc_tag, fill_tag;
  logic               hit, match;

  assign idx      = pc[INDEX_W+1:2];
  assign pc_tag   = pc[ADDR_W-1:INDEX_W+2];
  assign fill_idx = inst_pc_i[INDEX_W+1:2];
  assign fill_tag = inst_pc_i[ADDR_W-1:INDEX_W+2];
  assign hit      = valid[idx] && (tag_mem[idx] == pc_tag);
  assign match    = inst_ok_i && (inst_pc_i == pc);

  assign inst_fpc_o = pc;
  assign inst_fe_o  = ((state_q == RUN && !hit) || state_q == MISS) && !rst && !branch_i;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    if_pc_d    = if_pc_o;
    if_inst_d  = if_inst_o;
    if_valid_d = if_valid_o;
    if (branch_i) begin
      pc_d       = branch_target_i & ~32'h3;
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else if (stall_i) begin
      // A matching return under stall only fills; the released RUN cycle then hits.
      if (state_q == MISS && match) state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hit) begin
            if_pc_d    = pc;
            if_inst_d  = data_mem[idx];
            if_valid_d = 1'b1;
            pc_d       = pc + 32'd4;
          end else begin
            if_valid_d = 1'b0;
            state_d    = MISS;
          end
        end
        MISS: begin
          if (match) begin
            if_pc_d    = pc;
            if_inst_d  = inst_i;
            if_valid_d = 1'b1;
            pc_d       = pc + 32'd4;
            state_d    = RUN;
          end else begin
            if_valid_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc         <= 32'd0;
      if_pc_o    <= 32'd0;
      if_inst_o  <= 32'd0;
      if_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      if_pc_o    <= if_pc_d;
      if_inst_o  <= if_inst_d;
      if_valid_o <= if_valid_d;
    end
  end

  // Invalidate wins over a same-cycle fill; lookups this cycle still see the old contents.
  always_ff @(posedge clk) begin
    if (rst || ic_inv_i) begin
      valid <= '0;
    end else if (inst_ok_i) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid vector alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (inst_ok_i && !ic_inv_i) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= inst_i;
    end
  end

endmodule

// File: doc/if_fetch_icache.md
# if_fetch_icache

Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits between the pipeline's IF/ID register and the memory controller. It holds the architectural fetch PC and serves hits in one cycle. On a miss it drives the controller's `inst_fe`/`inst_fpc` request and fills the cache from every returned `inst_ok` word, including the controller's sequential prefetches. It also accepts branch redirects from EX and stall requests from the pipeline control.

## Interface
- `INDEX_W`, default 6: cache index width, giving 2^INDEX_W lines.
- `ADDR_W`, default 18: significant instruction address bits. Tag is `pc[ADDR_W-1 : INDEX_W+2]`.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `stall_i`  in  1  pipeline stall. Holds the PC and IF/ID outputs.
- `branch_i`  in  1  redirect request from EX.
- `branch_target_i`  in  32  redirect PC. Bits [1:0] are forced to 0.
- `ic_inv_i`  in  1  invalidate all lines (fence.i / self-modifying store).
- `inst_fe_o`  out  1  fetch request to the memory controller (combinational).
- `inst_fpc_o`  out  32  requested PC. Always equals `pc`.
- `inst_i`  in  32  returned instruction word.
- `inst_pc_i`  in  32  address of `inst_i`.
- `inst_ok_i`  in  1  one-cycle pulse: `inst_i` is valid.
- `if_pc_o`  out  32  registered PC to IF/ID.
- `if_inst_o`  out  32  registered instruction to IF/ID.
- `if_valid_o`  out  1  IF/ID slot holds a real instruction.

## Operation
- Storage per line: valid bit (flop vector), tag, and a 32-bit word. Lookup is combinational: `hit = valid[idx] & tag[idx]==pc tag`.
- FSM has two states, RUN and MISS.
- RUN, `hit` and not stalled: `if_*_o` <= {pc, word, 1}; `pc` <= pc+4.
- RUN, miss: `if_valid_o` <= 0 (unless stalled); go to MISS. `inst_fe_o` = 1 in the same cycle.
- MISS: `inst_fe_o` = 1 and `inst_fpc_o` = pc. Wait for `inst_ok_i` with `inst_pc_i==pc`.
  - On match, not stalled: bypass. Emit {pc, `inst_i`, 1}; `pc` <= pc+4; go to RUN.
  - On match, stalled: fill only, go to RUN. The next unstalled RUN cycle hits.
- `inst_fe_o` = (RUN & ~hit) | MISS, gated to 0 while `rst` or `branch_i` is high.
- Fill: every `inst_ok_i` pulse writes line `inst_pc_i[INDEX_W+1:2]` with its tag and sets valid, in any state and regardless of match. This covers stale returns for an abandoned PC and prefetch returns. On a same-cycle read and write to the same line, the lookup uses the pre-write contents.
- Priority: `rst` > `branch_i` > `ic_inv_i` > `stall_i` > normal.
  - `branch_i`: `pc` <= target & ~3; `if_valid_o` <= 0; state <= RUN. This applies even when `stall_i` is high.
  - `ic_inv_i`: all valid bits <= 0. A fill arriving in the same cycle is dropped. A lookup in that cycle still uses old state.
- `stall_i` (without branch): `pc`, `if_*_o` and state are held. Fills still occur.
- Reset values: `pc`=0, state=RUN, all valid bits=0, `if_pc_o`=0, `if_inst_o`=0, `if_valid_o`=0. `inst_fe_o` is 0 during reset.

## Timing
- Hit: lookup in cycle N, `if_valid_o` in N+1. Sustained throughput is 1 instruction per cycle.
- Miss: `inst_fe_o` rises combinationally in cycle N (the lookup cycle). If the matching `inst_ok_i` arrives in cycle M, `if_valid_o`=1 in M+1 and lookup of pc+4 happens in M+1.
- After a miss fill, the controller's prefetch of pc+4 fills the next line. The following fetch then hits, or returns via a matching `inst_ok_i`.
- Redirect: `branch_i` in cycle N gives a lookup of the target in N+1. First valid output is N+2 on a hit.
- `inst_fpc_o` changes only on a `pc` update. It is stable throughout MISS unless a redirect occurs; on a redirect the controller sees a new `inst_fpc` and aborts.

## Test plan
- Cold start: reset, memory holds words at 0x0, 0x4, 0x8. Required: `inst_fe_o`=1 with `inst_fpc_o`=0 on the first cycle after reset; three valid outputs with PCs 0, 4, 8 and the correct words; no `if_valid_o` before the first `inst_ok_i`+1.
- Hot loop: rerun 0x0–0x8 after a branch to 0x0. Required: `if_valid_o` high on 3 consecutive cycles, `inst_fe_o`=0 throughout.
- Redirect mid-miss: miss at 0x100; `branch_i`=1 with target 0x40 (cached) two cycles later. Required: `if_valid_o`=0 in the branch cycle +1; PC 0x40 valid at +2. The late `inst_ok_i` for 0x100 fills the line, so a later fetch of 0x100 hits.
- Conflict eviction (INDEX_W=6): fetch 0x0, then 0x100. Required: 0x100 misses and evicts; refetching 0x0 misses again.
- Stall during fill: `stall_i`=1 when the matching `inst_ok_i` arrives. Required: outputs are held; after the stall releases, the PC is emitted next cycle from a hit with `inst_fe_o`=0.
- Invalidate: `ic_inv_i` pulse after the hot loop. Required: the next fetch of 0x0 misses (`inst_fe_o`=1).
